// File: rtl/gelu_lut_loader.sv
// gelu_lut_loader: streams framed GELU LUT contents (header, 256 data, checksum) into
// a layered LUT BRAM and tracks per-layer "loaded and verified" flags.
`default_nettype none

module gelu_lut_loader #(
  parameter int NUM_LAYERS     = 4,
  parameter int DEPTH          = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic                  wr_en_o,
  output logic [9:0]            wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [NUM_LAYERS-1:0] lut_valid_o
);

  localparam int LAYER_W = 2;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0] HDR_TAG = 6'b101000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_CKSUM = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [LAYER_W-1:0]    layer;
  logic [IDX_W-1:0]      index;
  logic [7:0]            sum;
  logic [IDLE_W-1:0]     idle_cnt;
  logic                  accept;
  logic                  hdr_ok;
  logic                  timeout;
  logic                  last_idx;

  // Ready is held low only while reset is applied.
  assign s_ready_o = ~rst_i;
  assign accept    = s_valid_i & s_ready_o;
  assign hdr_ok    = (s_data_i[7:2] == HDR_TAG);
  assign last_idx  = (index == IDX_W'(DEPTH - 1));
  assign timeout   = (state != ST_IDLE) && !accept &&
                     (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && hdr_ok) state_nxt = ST_DATA;
      ST_DATA: begin
        if (accept && last_idx) state_nxt = ST_CKSUM;
        else if (timeout)       state_nxt = ST_IDLE;
      end
      ST_CKSUM: if (accept || timeout) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      layer       <= '0;
      index       <= '0;
      sum         <= '0;
      idle_cnt    <= '0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      lut_valid_o <= '0;
    end else begin
      wr_en_o <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;

      if (state == ST_IDLE || accept || timeout) idle_cnt <= '0;
      else                                        idle_cnt <= idle_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (hdr_ok) begin
              layer                        <= s_data_i[LAYER_W-1:0];
              index                        <= '0;
              sum                          <= '0;
              lut_valid_o[s_data_i[1:0]]   <= 1'b0;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= {layer, index};
            wr_data_o <= s_data_i;
            index     <= index + 1'b1;
            sum       <= sum + s_data_i;
          end else if (timeout) begin
            err_o <= 1'b1;
          end
        end
        ST_CKSUM: begin
          if (accept) begin
            if (s_data_i == sum) begin
              done_o             <= 1'b1;
              lut_valid_o[layer] <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end else if (timeout) begin
            err_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gelu_lut_loader.sv
// Self-checking bench for gelu_lut_loader: directed and randomized frames against a frame-level model.
`timescale 1ns/1ps
`default_nettype none

module tb_gelu_lut_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready, wr_en, busy, done, err;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] lut_valid;

  gelu_lut_loader #(.NUM_LAYERS(4), .DEPTH(256), .TIMEOUT_CYCLES(1024)) dut (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy),
    .done_o(done), .err_o(err), .lut_valid_o(lut_valid)
  );

  always #5 clk = ~clk;

  // Observed side: LUT image and event counters, sampled on the falling edge.
  bit [7:0] mem_act [1024];
  int wr_cnt, done_cnt, err_cnt, both_cnt, busy_cyc, b2b_cnt;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (wr_en) begin
      mem_act[wr_addr] = wr_data;
      wr_cnt++;
      if (prev_wr) b2b_cnt++;
    end
    prev_wr = wr_en;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (busy) busy_cyc++;
  end

  // Expected side.
  bit [7:0] mem_exp [1024];
  bit [3:0] valid_exp;
  bit [7:0] frame_data [256];
  int exp_wr, exp_done, exp_err;
  int snap_wr, snap_done, snap_err, snap_busy, snap_b2b;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_data  = b;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic snapshot();
    snap_wr = wr_cnt; snap_done = done_cnt; snap_err = err_cnt;
    snap_busy = busy_cyc; snap_b2b = b2b_cnt;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int n, input bit with_cks,
                            input logic [7:0] cks, input int max_gap);
    snapshot();
    send_byte(hdr, $urandom_range(0, max_gap));
    for (int i = 0; i < n; i++) send_byte(frame_data[i], $urandom_range(0, max_gap));
    if (with_cks) send_byte(cks, $urandom_range(0, max_gap));
  endtask

  // Frame semantics: a tagged header opens a layer, data fills it in order,
  // the checksum byte decides verified/error; missing checksum means timeout.
  task automatic model_frame(input logic [7:0] hdr, input int n, input bit with_cks,
                             input logic [7:0] cks);
    int s;
    int ly;
    exp_wr = 0; exp_done = 0; exp_err = 0;
    if (hdr[7:2] != 6'b101000) begin
      exp_err = 1;
      return;
    end
    ly = int'(hdr[1:0]);
    valid_exp[ly] = 1'b0;
    s = 0;
    for (int i = 0; i < n; i++) begin
      mem_exp[ly * 256 + i] = frame_data[i];
      s = s + int'(frame_data[i]);
    end
    exp_wr = n;
    if (!with_cks) exp_err = 1;
    else if ((s % 256) == int'(cks)) begin
      exp_done = 1;
      valid_exp[ly] = 1'b1;
    end else exp_err = 1;
  endtask

  task automatic check_frame(input string tag);
    int mism;
    repeat (3) begin @(posedge clk); #1; end
    mism = 0;
    for (int a = 0; a < 1024; a++) if (mem_act[a] != mem_exp[a]) mism++;
    check({tag, "_writes"}, 32'(wr_cnt - snap_wr), 32'(exp_wr));
    check({tag, "_done"}, 32'(done_cnt - snap_done), 32'(exp_done));
    check({tag, "_err"}, 32'(err_cnt - snap_err), 32'(exp_err));
    check({tag, "_lut_valid"}, 32'(lut_valid), 32'(valid_exp));
    check({tag, "_lut_image"}, 32'(mism), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [7:0] sum_of_data();
    int s = 0;
    for (int i = 0; i < 256; i++) s += int'(frame_data[i]);
    return 8'(s);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cks;
    logic [7:0] hdr;
    int waited;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_outs", 32'({wr_en, busy, done, err}), 32'd0);
    check("rst_addr_data", 32'({wr_addr, wr_data}), 32'd0);
    check("rst_lut_valid", 32'(lut_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(s_ready), 32'd1);

    // Layer 2 identity frame, good checksum, no gaps
    for (int i = 0; i < 256; i++) frame_data[i] = 8'(i);
    send_frame(8'hA2, 8, 1'b0, 8'h00, 0);
    check("l2_busy_mid", 32'(busy), 32'd1);
    for (int i = 8; i < 256; i++) send_byte(frame_data[i], 0);
    send_byte(8'h80, 0);
    model_frame(8'hA2, 256, 1'b1, 8'h80);
    check_frame("l2_good");
    check("l2_b2b", 32'(b2b_cnt - snap_b2b), 32'd255);

    // Same frame with a wrong checksum
    send_frame(8'hA2, 256, 1'b1, 8'h81, 0);
    model_frame(8'hA2, 256, 1'b1, 8'h81);
    check_frame("l2_badck");

    // Invalid header
    send_frame(8'h55, 0, 1'b0, 8'h00, 0);
    model_frame(8'h55, 0, 1'b0, 8'h00);
    check_frame("bad_hdr");
    check("bad_hdr_busy", 32'(busy_cyc - snap_busy), 32'd0);

    // Layer 1 good frame, then a truncated layer 1 frame that times out
    for (int i = 0; i < 256; i++) frame_data[i] = 8'($urandom);
    send_frame(8'hA1, 256, 1'b1, sum_of_data(), 1);
    model_frame(8'hA1, 256, 1'b1, sum_of_data());
    check_frame("l1_good");
    for (int i = 0; i < 256; i++) frame_data[i] = 8'($urandom);
    send_frame(8'hA1, 10, 1'b0, 8'h00, 0);
    check("l1_valid_drop", 32'(lut_valid[1]), 32'd0);
    repeat (1000) @(posedge clk);
    #1;
    check("to_not_early", 32'(err_cnt - snap_err), 32'd0);
    waited = 0;
    while ((err_cnt == snap_err) && (waited < 100)) begin
      @(posedge clk); #1;
      waited++;
    end
    model_frame(8'hA1, 10, 1'b0, 8'h00);
    check_frame("l1_timeout");
    // The loader must be back in IDLE and accept a fresh frame.
    for (int i = 0; i < 256; i++) frame_data[i] = 8'($urandom);
    send_frame(8'hA1, 256, 1'b1, sum_of_data(), 0);
    model_frame(8'hA1, 256, 1'b1, sum_of_data());
    check_frame("l1_reload");

    // Layer 3 all 0xFF with random gaps, checksum wraps to 0x00
    for (int i = 0; i < 256; i++) frame_data[i] = 8'hFF;
    send_frame(8'hA3, 256, 1'b1, 8'h00, 4);
    model_frame(8'hA3, 256, 1'b1, 8'h00);
    check_frame("l3_ff");

    // Random frames: random layer, data, gaps, good or corrupted checksum
    for (int f = 0; f < 4; f++) begin
      hdr = {6'b101000, 2'($urandom)};
      for (int i = 0; i < 256; i++) frame_data[i] = 8'($urandom);
      cks = sum_of_data();
      if ($urandom_range(0, 1) == 1) cks = cks + 8'($urandom_range(1, 255));
      send_frame(hdr, 256, 1'b1, cks, 2);
      model_frame(hdr, 256, 1'b1, cks);
      check_frame("rand");
    end

    // Reset at data index 100 of a layer 0 frame
    for (int i = 0; i < 256; i++) frame_data[i] = 8'($urandom);
    send_frame(8'hA0, 100, 1'b0, 8'h00, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outs", 32'({s_ready, wr_en, busy, done, err}), 32'd0);
    check("midrst_addr_data", 32'({wr_addr, wr_data}), 32'd0);
    check("midrst_lut_valid", 32'(lut_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_frame(8'hA0, 100, 1'b0, 8'h00);
    exp_err = 0;
    valid_exp = 4'b0000;
    check_frame("midrst");
    send_frame(8'hA0, 256, 1'b1, sum_of_data(), 1);
    model_frame(8'hA0, 256, 1'b1, sum_of_data());
    check_frame("l0_after_rst");

    check("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gelu_lut_loader.md
GELU_LUT_LOADER -- requirements
Module: gelu_lut_loader

Interface
REQ-001 Parameter NUM_LAYERS, 4: number of GELU LUT layers; layer field is 2 bits.
REQ-002 Parameter DEPTH, 256: entries per layer; entry index is 8 bits.
REQ-003 Parameter TIMEOUT_CYCLES, 1024: maximum idle cycles allowed between bytes inside a frame.
REQ-004 Port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst_i, input, 1: synchronous, active-high reset.
REQ-006 Port s_data_i, input, 8: incoming stream byte.
REQ-007 Port s_valid_i, input, 1: s_data_i is valid.
REQ-008 Port s_ready_o, output, 1: loader accepts a byte this cycle.
REQ-009 Port wr_en_o, output, 1: LUT BRAM write strobe.
REQ-010 Port wr_addr_o, output, 10: LUT write address {layer[1:0], index[7:0]}.
REQ-011 Port wr_data_o, output, 8: LUT write data.
REQ-012 Port busy_o, output, 1: high when a frame is in progress (state not IDLE).
REQ-013 Port done_o, output, 1: one-cycle pulse on a frame with a good checksum.
REQ-014 Port err_o, output, 1: one-cycle pulse on a bad header, bad checksum or timeout.
REQ-015 Port lut_valid_o, output, 4: per-layer "contents loaded and verified" flags.

Function
REQ-016 A byte is transferred only in a cycle with s_valid_i=1 and s_ready_o=1; s_ready_o is 1 in every state when rst_i=0.
REQ-017 Frame format: header byte, then 256 data bytes for index 0..255, then 1 checksum byte.
REQ-018 The header byte is valid when bits[7:2]=6'b101000; bits[1:0] select the layer.
REQ-019 The checksum byte equals the sum of the 256 data bytes, mod 256.
REQ-020 FSM states: IDLE, DATA, CKSUM.
REQ-021 FSM transitions:
- IDLE -> DATA on a valid header.
- DATA -> CKSUM when data byte index 255 is accepted.
- CKSUM -> IDLE when the checksum byte is accepted.
REQ-022 An invalid header byte accepted in IDLE is discarded: state stays IDLE, err_o pulses the next cycle, and nothing is written.
REQ-023 Accepting a valid header clears lut_valid_o[layer] on the next cycle, latches the layer, and zeroes the index counter and the 8-bit running sum.
REQ-024 Each data byte accepted in DATA produces, on the next cycle:
- wr_en_o=1
- wr_data_o = the accepted byte
- wr_addr_o = {layer, index}
REQ-025 Each accepted data byte increments the index counter and adds into the running sum, which wraps mod 256.
REQ-026 wr_en_o is 0 in every cycle not covered by REQ-024; wr_addr_o and wr_data_o hold their last values when wr_en_o=0.
REQ-027 Back-to-back data bytes produce back-to-back writes; write throughput is 1 byte per cycle.
REQ-028 Index 255 wraps the index counter to 0 without affecting the latched layer.
REQ-029 Checksum byte accepted and equal to the running sum: next cycle done_o=1 and lut_valid_o[layer] is set.
REQ-030 Checksum byte accepted and not equal to the running sum: next cycle err_o=1 and lut_valid_o[layer] stays 0; written entries are not rolled back.
REQ-031 The idle counter counts cycles in DATA or CKSUM with no accepted byte; it clears on every accepted byte.
REQ-032 When the idle counter reaches TIMEOUT_CYCLES: go to IDLE, pulse err_o next cycle, and leave lut_valid_o[layer] cleared.
REQ-033 A header-pattern byte received in DATA is treated as data; there is no resynchronisation inside a frame.
REQ-034 done_o and err_o are never high in the same cycle.
REQ-035 lut_valid_o bits of other layers are unaffected by any frame.
REQ-036 busy_o is 1 from the cycle after header acceptance until the cycle after checksum acceptance or timeout.

Reset
REQ-037 While rst_i=1, on each clock edge:
- state = IDLE
- index, sum and idle counter = 0
- wr_en_o = 0, wr_addr_o = 0, wr_data_o = 0
- busy_o = 0, done_o = 0, err_o = 0
- lut_valid_o = 4'b0000
- s_ready_o = 0
REQ-038 Reset asserted mid-frame aborts the frame with no err_o pulse; writes already issued remain in the LUT.

Verification
REQ-039 Frame with header 0xA2, data byte i = i, checksum 0x80 -> 256 writes to addresses 0x200..0x2FF with data = low byte of the address, done_o pulse, lut_valid_o = 4'b0100.
REQ-040 Same frame with checksum 0x81 -> same 256 writes, err_o pulse, no done_o, lut_valid_o[2] = 0.
REQ-041 Header 0x55 in IDLE -> err_o pulse, no writes, busy_o stays 0.
REQ-042 Layer 1 loaded OK, then a layer 1 header followed by 10 bytes and 1024 idle cycles -> lut_valid_o[1] drops after the header, err_o pulses on timeout, state returns to IDLE.
REQ-043 Random s_valid_i gaps (< TIMEOUT_CYCLES) during a layer 3 frame with all data bytes 0xFF, checksum 0x00 -> writes at addresses 0x300..0x3FF, done_o pulse, lut_valid_o[3] = 1.
REQ-044 rst_i asserted at data index 100 of a layer 0 frame -> all outputs take reset values and the next valid frame loads normally.
